heap_out_drain: RTL and testbench

// - Consumer at the output end of heap_rtl. Each cycle, on valid, it accepts the heap's two-word

---
 rtl/heap_pkg.sv | 20 ++
 rtl/heap_out_drain_if.sv | 13 +
 rtl/heap_out_drain_fifo_2w1r.sv | 59 +++++
 rtl/heap_out_drain.sv | 117 +++++++++++
 tb/tb_heap_out_drain.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap output path: word tags, pad/sentinel words, FSM encoding.
// Pure declarations; no timing or flow control of its own.
package heap_pkg;

    localparam logic [1:0] TAG_KEEP  = 2'b00;
    localparam logic [1:0] TAG_INIT  = 2'b01;
    localparam logic [1:0] TAG_FLUSH = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Pad words carry the key extreme that sorts to the far end for the given ordering.
    function automatic logic [15:0] init_data(input bit max_mode);
        return max_mode ? 16'h4FFF : 16'h4000;
    endfunction

    function automatic logic [15:0] flush_data(input bit max_mode);
        return max_mode ? 16'hC000 : 16'hCFFF;
    endfunction

endpackage

// File: rtl/heap_out_drain_if.sv
// Heap pair input and single-word valid/ready output of the drain block.
// master = producer/consumer side (bench), slave = drain block.
interface heap_out_drain_if #(parameter int DATA_WIDTH = 16);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_d1;
    logic [DATA_WIDTH-1:0] in_d2;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output in_valid, in_d1, in_d2, m_ready, input m_data, m_valid);
    modport slave  (input in_valid, in_d1, in_d2, m_ready, output m_data, m_valid);
endinterface

// File: rtl/heap_out_drain_fifo_2w1r.sv
// Two-write/one-read FIFO; writes visible on rd_dat_o one cycle later, pop on rd_en_i.
// No internal backpressure: the caller must never write beyond free space or pop when empty.
module fifo_2w1r #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  wr_en1_i,
    input  logic [DATA_WIDTH-1:0] wr_d1_i,
    input  logic                  wr_en2_i,
    input  logic [DATA_WIDTH-1:0] wr_d2_i,
    input  logic                  rd_en_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx2;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // d2 lands behind d1 when both are written in the same cycle.
    assign wr_idx2 = wr_ptr_q + DEPTH_LOG2'(wr_en1_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_en1_i) + DEPTH_LOG2'(wr_en2_i);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_en_i);
        count_d  = count_q + (DEPTH_LOG2+1)'(wr_en1_i) + (DEPTH_LOG2+1)'(wr_en2_i)
                 - (DEPTH_LOG2+1)'(rd_en_i);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_i && wr_en1_i) mem_q[wr_ptr_q] <= wr_d1_i;
        if (!clr_i && wr_en2_i) mem_q[wr_idx2]  <= wr_d2_i;
    end

    assign count_o  = count_q;
    assign rd_dat_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/heap_out_drain.sv
// Strips pad words from heap output pairs, buffers kept keys, re-emits them with an order check.
// Output appears one cycle after write; m_ready backpressure fills the FIFO, excess words drop and set ovf.
module heap_out_drain
    import heap_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 12,
    parameter int DEPTH_LOG2 = 5,
    parameter bit MAX_MODE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 init,
    heap_out_drain_if.slave      bus,
    output logic                 done,
    output logic                 order_err,
    output logic                 ovf,
    output logic [15:0]          out_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2:0]   count, free;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [1:0]            tag1, tag2;
    logic [KEY_WIDTH-1:0]  key1, key2, ref2, last_key_q;
    logic                  accept, keep1, keep2, flush, wr1, wr2, drop, pop;
    logic                  have2, err1, err2;
    logic                  have_last_q, order_err_q, ovf_q;
    logic [15:0]           out_cnt_q;

    function automatic logic out_of_order(input logic [KEY_WIDTH-1:0] k,
                                          input logic [KEY_WIDTH-1:0] prev);
        return MAX_MODE ? (k > prev) : (k < prev);
    endfunction

    assign accept = bus.in_valid && !init && (state_q == RUN || state_q == DRAIN);
    assign tag1   = bus.in_d1[DATA_WIDTH-1 -: 2];
    assign tag2   = bus.in_d2[DATA_WIDTH-1 -: 2];
    assign key1   = bus.in_d1[KEY_WIDTH-1:0];
    assign key2   = bus.in_d2[KEY_WIDTH-1:0];
    assign keep1  = accept && (tag1 == TAG_KEEP);
    assign keep2  = accept && (tag2 == TAG_KEEP);
    assign flush  = accept && (tag1 == TAG_FLUSH || tag2 == TAG_FLUSH);

    // Space is judged before this cycle's pop, so a full FIFO drops even while draining.
    assign free = (DEPTH_LOG2+1)'(DEPTH) - count;
    assign wr1  = keep1 && (free != '0);
    assign wr2  = keep2 && (keep1 ? (free >= (DEPTH_LOG2+1)'(2)) : (free != '0));
    assign drop = (keep1 && !wr1) || (keep2 && !wr2);
    assign pop  = bus.m_valid && bus.m_ready;

    // d2 is compared against d1 when d1 was written this cycle.
    assign ref2  = wr1 ? key1 : last_key_q;
    assign have2 = wr1 || have_last_q;
    assign err1  = wr1 && have_last_q && out_of_order(key1, last_key_q);
    assign err2  = wr2 && have2 && out_of_order(key2, ref2);

    fifo_2w1r #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (init),
        .wr_en1_i (wr1),
        .wr_d1_i  (bus.in_d1),
        .wr_en2_i (wr2),
        .wr_d2_i  (bus.in_d2),
        .rd_en_i  (pop),
        .count_o  (count),
        .rd_dat_o (rd_dat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (count == '0 && !wr1 && !wr2) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (init) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            last_key_q  <= '0;
            have_last_q <= 1'b0;
            order_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (init) begin
                have_last_q <= 1'b0;
                order_err_q <= 1'b0;
                ovf_q       <= 1'b0;
                out_cnt_q   <= '0;
            end else begin
                if (wr2)      last_key_q <= key2;
                else if (wr1) last_key_q <= key1;
                have_last_q <= have_last_q | wr1 | wr2;
                order_err_q <= order_err_q | err1 | err2;
                ovf_q       <= ovf_q | drop;
                if (pop) out_cnt_q <= out_cnt_q + 16'd1;
            end
        end
    end

    assign bus.m_valid = (count != '0);
    assign bus.m_data  = {2'b00, rd_dat[DATA_WIDTH-3:0]};
    assign done        = (state_q == DONE);
    assign order_err   = order_err_q;
    assign ovf         = ovf_q;
    assign out_cnt     = out_cnt_q;

endmodule

// File: tb/tb_heap_out_drain.sv
// Directed bench for heap_out_drain: ordering, pad stripping, overflow, flush/done and reset paths.
module tb_heap_out_drain;
    import heap_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        init = 1'b0;
    logic        done0, order_err0, ovf0, done1, order_err1, ovf1;
    logic [15:0] out_cnt0, out_cnt1;
    logic [15:0] rx[$];
    int          checks = 0;
    int          failures = 0;
    int          n_done;

    heap_out_drain_if #(.DATA_WIDTH(16)) bus0();
    heap_out_drain_if #(.DATA_WIDTH(16)) bus1();

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_d1    = bus0.in_d1;
    assign bus1.in_d2    = bus0.in_d2;
    assign bus1.m_ready  = 1'b1;

    heap_out_drain #(.MAX_MODE(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .init(init), .bus(bus0.slave),
        .done(done0), .order_err(order_err0), .ovf(ovf0), .out_cnt(out_cnt0)
    );

    heap_out_drain #(.MAX_MODE(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .init(init), .bus(bus1.slave),
        .done(done1), .order_err(order_err1), .ovf(ovf1), .out_cnt(out_cnt1)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so a handshake seen at negedge is the one taken.
    always @(negedge clk)
        if (rstn && bus0.m_valid && bus0.m_ready) rx.push_back(bus0.m_data);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        bus0.in_valid = 1'b1;
        bus0.in_d1    = a;
        bus0.in_d2    = b;
        tick();
        bus0.in_valid = 1'b0;
    endtask

    initial begin
        bus0.in_valid = 1'b0;
        bus0.in_d1    = '0;
        bus0.in_d2    = '0;
        bus0.m_ready  = 1'b0;

        #3;
        chk("rst_m_valid", 32'(bus0.m_valid), 32'd0);
        chk("rst_m_data",  32'(bus0.m_data),  32'd0);
        chk("rst_done",    32'(done0),        32'd0);
        chk("rst_err",     32'(order_err0),   32'd0);
        chk("rst_ovf",     32'(ovf0),         32'd0);
        chk("rst_cnt",     32'(out_cnt0),     32'd0);
        ticks(2);
        rstn = 1'b1;
        tick();

        // Idle ignores input until the first init.
        send_pair(16'h0001, 16'h0002);
        chk("idle_ignore", 32'(bus0.m_valid), 32'd0);

        // Ascending stream, consumer always ready.
        pulse_init();
        rx.delete();
        bus0.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_pair(16'(2*i + 1), 16'(2*i + 2));
        ticks(24);
        chk("asc_n", 32'(rx.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            chk($sformatf("asc_w%0d", i), 32'(rx[i]), 32'(i + 1));
        chk("asc_cnt", 32'(out_cnt0),   32'd16);
        chk("asc_err", 32'(order_err0), 32'd0);

        // Init pads are stripped.
        pulse_init();
        rx.delete();
        send_pair(init_data(1'b0), init_data(1'b0));
        send_pair(16'h0005, 16'h0007);
        ticks(6);
        chk("pad_n", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("pad_w0", 32'(rx[0]), 32'h005);
            chk("pad_w1", 32'(rx[1]), 32'h007);
        end
        chk("pad_cnt", 32'(out_cnt0), 32'd2);

        // Overflow: 20 pairs into a 32-word FIFO with no consumer.
        pulse_init();
        rx.delete();
        bus0.m_ready = 1'b0;
        for (int j = 1; j <= 16; j++) send_pair(16'(2*j - 1), 16'(2*j));
        chk("ovf_full_ovf",   32'(ovf0),        32'd0);
        chk("ovf_full_vld",   32'(bus0.m_valid), 32'd1);
        chk("ovf_hold_data",  32'(bus0.m_data),  32'h001);
        send_pair(16'd33, 16'd34);
        chk("ovf_set", 32'(ovf0), 32'd1);
        for (int j = 18; j <= 20; j++) send_pair(16'(2*j - 1), 16'(2*j));
        chk("ovf_hold_data2", 32'(bus0.m_data), 32'h001);
        bus0.m_ready = 1'b1;
        ticks(40);
        chk("ovf_n", 32'(rx.size()), 32'd32);
        for (int i = 0; i < 32 && i < rx.size(); i++)
            chk($sformatf("ovf_w%0d", i), 32'(rx[i]), 32'(i + 1));
        chk("ovf_cnt",    32'(out_cnt0),   32'd32);
        chk("ovf_sticky", 32'(ovf0),       32'd1);
        chk("ovf_err",    32'(order_err0), 32'd0);

        // Ordering check in both modes.
        pulse_init();
        send_pair(16'h0010, 16'h000F);
        chk("ord_min_err", 32'(order_err0), 32'd1);
        chk("ord_max_ok",  32'(order_err1), 32'd0);
        send_pair(16'h0020, 16'h0030);
        ticks(4);
        chk("ord_sticky", 32'(order_err0), 32'd1);
        pulse_init();
        chk("ord_clear", 32'(order_err0), 32'd0);
        ticks(2);

        // Flush with 3 words buffered, then drain to done.
        pulse_init();
        bus0.m_ready = 1'b0;
        send_pair(16'h0001, 16'h0002);
        send_pair(16'h0003, init_data(1'b0));
        send_pair(flush_data(1'b0), flush_data(1'b0));
        rx.delete();
        chk("fl_done0", 32'(done0), 32'd0);
        bus0.m_ready = 1'b1;
        ticks(3);
        chk("fl_empty",     32'(bus0.m_valid), 32'd0);
        chk("fl_not_yet",   32'(done0),        32'd0);
        tick();
        chk("fl_done",      32'(done0),        32'd1);
        tick();
        chk("fl_done_once", 32'(done0),        32'd0);
        chk("fl_n",   32'(rx.size()), 32'd3);
        if (rx.size() == 3) chk("fl_w2", 32'(rx[2]), 32'h003);
        chk("fl_cnt", 32'(out_cnt0), 32'd3);
        send_pair(16'h0009, 16'h000A);
        chk("fl_idle_ignore", 32'(bus0.m_valid), 32'd0);

        // Async reset mid-run with 10 words buffered.
        pulse_init();
        send_pair(16'h0020, 16'h0021);
        ticks(3);
        bus0.m_ready = 1'b0;
        for (int j = 0; j < 5; j++) send_pair(16'(10 - 2*j), 16'(9 - 2*j));
        chk("ar_pre_err", 32'(order_err0), 32'd1);
        chk("ar_pre_cnt", 32'(out_cnt0),   32'd2);
        chk("ar_pre_vld", 32'(bus0.m_valid), 32'd1);
        rstn = 1'b0;
        #2;
        chk("ar_vld",  32'(bus0.m_valid), 32'd0);
        chk("ar_data", 32'(bus0.m_data),  32'd0);
        chk("ar_err",  32'(order_err0),   32'd0);
        chk("ar_cnt",  32'(out_cnt0),     32'd0);
        chk("ar_ovf",  32'(ovf0),         32'd0);
        chk("ar_done", 32'(done0),        32'd0);
        tick();
        rstn = 1'b1;
        tick();
        send_pair(16'h0001, 16'h0002);
        chk("ar_idle_ignore", 32'(bus0.m_valid), 32'd0);

        // Init while draining cancels the stream without a done pulse.
        pulse_init();
        bus0.m_ready = 1'b0;
        send_pair(16'h0005, 16'h0004);
        send_pair(flush_data(1'b0), flush_data(1'b0));
        chk("id_pre_err", 32'(order_err0), 32'd1);
        pulse_init();
        chk("id_vld", 32'(bus0.m_valid), 32'd0);
        chk("id_err", 32'(order_err0),   32'd0);
        chk("id_cnt", 32'(out_cnt0),     32'd0);
        bus0.m_ready = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done0) n_done++;
        end
        chk("id_no_done", 32'(n_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
